// File: rtl/xcorr_burst_ctrl.sv
// Burst scheduler gating the I/Q stream into BURST_LEN-sample bursts for the ping-pong downsampler.
// Optional back-to-back re-arm at burst end: define XCORR_BURST_AUTO_REARM_EN.
module xcorr_burst_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int BURST_LEN  = 2048,
  parameter int OFS_W      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [OFS_W-1:0]      cfg_offset,
  input  logic                  trig,
  input  logic                  rd_done,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic [DATA_WIDTH-1:0] s_data_q,
  input  logic                  s_valid,
  output logic [DATA_WIDTH-1:0] out_data_i,
  output logic [DATA_WIDTH-1:0] out_data_q,
  output logic                  out_valid,
  output logic                  buf_sel,
  output logic                  burst_done,
  output logic                  busy,
  output logic [1:0]            credits,
  output logic                  overflow,
  output logic                  credit_err,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int SC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [SC_W-1:0] LAST_IDX = SC_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SKIP, BURST} state_t;

  state_t           state, state_nxt;
  logic [SC_W-1:0]  sample_cnt;
  logic [OFS_W-1:0] skip_cnt;
  logic             consume, refund, drop, load_skip, skip_dec, fwd, last;
  logic [2:0]       credits_sum;
  logic [1:0]       credits_nxt;

`ifdef XCORR_BURST_AUTO_REARM_EN
  logic [1:0] credits_upd;
  assign credits_upd = (rd_done && credits != 2'd2) ? credits + 2'd1 : credits;
`endif

  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    refund    = 1'b0;
    drop      = 1'b0;
    load_skip = 1'b0;
    skip_dec  = 1'b0;
    fwd       = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_enable) state_nxt = ARMED;
      end
      ARMED: begin
        if (!cfg_enable) begin
          state_nxt = IDLE;
        end else if (trig) begin
          if (credits != 2'd0) begin
            consume = 1'b1;
            if (cfg_offset == '0) begin
              state_nxt = BURST;
            end else begin
              state_nxt = SKIP;
              load_skip = 1'b1;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end
      SKIP: begin
        if (!cfg_enable) begin
          state_nxt = IDLE;
          refund    = 1'b1;
        end else if (s_valid) begin
          skip_dec = 1'b1;
          if (skip_cnt == OFS_W'(1)) state_nxt = BURST;
        end
      end
      BURST: begin
        if (s_valid) begin
          fwd = 1'b1;
          if (sample_cnt == LAST_IDX) begin
            last = 1'b1;
`ifdef XCORR_BURST_AUTO_REARM_EN
            if (cfg_enable && credits_upd != 2'd0) begin
              consume   = 1'b1;
              state_nxt = BURST;
            end else begin
              state_nxt = cfg_enable ? ARMED : IDLE;
            end
`else
            state_nxt = cfg_enable ? ARMED : IDLE;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum first, then saturate: a same-cycle consume and return always cancel.
  always_comb begin
    credits_sum = {1'b0, credits} + {2'b00, rd_done} + {2'b00, refund} - {2'b00, consume};
    credits_nxt = (credits_sum > 3'd2) ? 2'd2 : credits_sum[1:0];
  end

  assign busy = (state == SKIP) || (state == BURST);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      out_data_i <= '0;
      out_data_q <= '0;
      out_valid  <= 1'b0;
      burst_done <= 1'b0;
      buf_sel    <= 1'b0;
      credits    <= 2'd2;
      overflow   <= 1'b0;
      credit_err <= 1'b0;
      drop_cnt   <= '0;
      sample_cnt <= '0;
      skip_cnt   <= '0;
    end else begin
      out_valid  <= fwd;
      out_data_i <= fwd ? s_data_i : '0;
      out_data_q <= fwd ? s_data_q : '0;
      burst_done <= last;
      credits    <= credits_nxt;
      if (last) buf_sel <= ~buf_sel;
      if (last) begin
        sample_cnt <= '0;
      end else if (fwd) begin
        sample_cnt <= sample_cnt + SC_W'(1);
      end
      if (load_skip) begin
        skip_cnt <= cfg_offset;
      end else if (skip_dec) begin
        skip_cnt <= skip_cnt - OFS_W'(1);
      end
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (rd_done && credits == 2'd2) credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xcorr_burst_ctrl.sv
// Bench for xcorr_burst_ctrl: behavioural model checked every cycle, directed scenarios, random phase.
module tb_xcorr_burst_ctrl;

  localparam int DW = 12;
  localparam int BL = 8;
  localparam int OW = 16;
  localparam int CW = 3;
  localparam int DROP_MAX = 7;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_enable = 1'b0;
  logic [OW-1:0] cfg_offset = '0;
  logic          trig = 1'b0;
  logic          rd_done = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic [DW-1:0] s_data_q = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] out_data_i, out_data_q;
  logic          out_valid, buf_sel, burst_done, busy, overflow, credit_err;
  logic [1:0]    credits;
  logic [CW-1:0] drop_cnt;

  xcorr_burst_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL), .OFS_W(OW), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst(rst), .cfg_enable(cfg_enable), .cfg_offset(cfg_offset),
    .trig(trig), .rd_done(rd_done), .s_data_i(s_data_i), .s_data_q(s_data_q),
    .s_valid(s_valid), .out_data_i(out_data_i), .out_data_q(out_data_q),
    .out_valid(out_valid), .buf_sel(buf_sel), .burst_done(burst_done), .busy(busy),
    .credits(credits), .overflow(overflow), .credit_err(credit_err), .drop_cnt(drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 waiting for trigger, 2 skipping offset, 3 in burst.
  int   m_mode, m_cr, m_skip, m_n, m_drop, cons, refund;
  bit   m_buf, m_ovf, m_cerr, started;
  logic e_valid, e_done;
  logic [DW-1:0] e_di, e_dq;

  initial started = 0;

  always @(posedge clk_in) begin
    e_valid = 0; e_done = 0; e_di = '0; e_dq = '0;
    cons = 0; refund = 0;
    if (rst) begin
      m_mode = 0; m_cr = 2; m_skip = 0; m_n = 0; m_drop = 0;
      m_buf = 0; m_ovf = 0; m_cerr = 0;
    end else begin
      if (rd_done && m_cr == 2) m_cerr = 1;
      case (m_mode)
        0: if (cfg_enable) m_mode = 1;
        1: begin
          if (!cfg_enable) m_mode = 0;
          else if (trig) begin
            if (m_cr > 0) begin
              cons = 1;
              if (cfg_offset == 0) m_mode = 3;
              else begin m_mode = 2; m_skip = int'(cfg_offset); end
            end else begin
              m_ovf = 1;
              if (m_drop < DROP_MAX) m_drop++;
            end
          end
        end
        2: begin
          if (!cfg_enable) begin m_mode = 0; refund = 1; end
          else if (s_valid) begin
            m_skip--;
            if (m_skip == 0) m_mode = 3;
          end
        end
        default: begin
          if (s_valid) begin
            e_valid = 1; e_di = s_data_i; e_dq = s_data_q;
            m_n++;
            if (m_n == BL) begin
              e_done = 1; m_n = 0; m_buf = !m_buf;
`ifdef XCORR_BURST_AUTO_REARM_EN
              if (cfg_enable && ((m_cr + int'(rd_done)) > 0)) begin
                cons = 1; m_mode = 3;
              end else m_mode = cfg_enable ? 1 : 0;
`else
              m_mode = cfg_enable ? 1 : 0;
`endif
            end
          end
        end
      endcase
      m_cr = m_cr + int'(rd_done) + refund - cons;
      if (m_cr > 2) m_cr = 2;
    end
    started = 1;
  end

  int seen_q[$];
  int done_data, done_cnt;

  always @(negedge clk_in) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_data_i", 32'(out_data_i), 32'(e_di));
      chk("out_data_q", 32'(out_data_q), 32'(e_dq));
      chk("burst_done", 32'(burst_done), 32'(e_done));
      chk("buf_sel", 32'(buf_sel), 32'(m_buf));
      chk("busy", 32'(busy), 32'(m_mode >= 2));
      chk("credits", 32'(credits), 32'(m_cr));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("credit_err", 32'(credit_err), 32'(m_cerr));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (out_valid === 1'b1) seen_q.push_back(int'(out_data_i));
      if (burst_done === 1'b1) begin done_data = int'(out_data_i); done_cnt++; end
    end
  end

  task automatic cyc(input logic tv, input logic rv, input logic vv, input int d);
    @(negedge clk_in); #1;
    trig = tv; rd_done = rv; s_valid = vv;
    s_data_i = DW'(d); s_data_q = DW'(d * 3 + 5);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic samples(input int first, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1, first + k);
  endtask

  initial begin
    done_cnt = 0; done_data = 0;
    idle(3);
    rst = 1'b0;
    chk("rst_credits", 32'(credits), 2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    cfg_enable = 1'b1;
    idle(1);
`ifdef XCORR_BURST_AUTO_REARM_EN
    seen_q.delete(); done_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(1, 16);
    idle(2);
    chk("auto_count", 32'(seen_q.size()), 16);
    chk("auto_dones", 32'(done_cnt), 2);
    chk("auto_credits", 32'(credits), 0);
    chk("auto_buf_sel", 32'(buf_sel), 0);
    chk("auto_last", 32'(done_data), 16);
`else
    // Plain burst, no offset
    seen_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(1, 8);
    idle(2);
    chk("t1_count", 32'(seen_q.size()), 8);
    chk("t1_first", 32'(seen_q[0]), 1);
    chk("t1_last", 32'(seen_q[7]), 8);
    chk("t1_done_data", 32'(done_data), 8);
    chk("t1_credits", 32'(credits), 1);
    chk("t1_buf_sel", 32'(buf_sel), 1);
    // Offset of 3
    seen_q.delete();
    cfg_offset = 16'd3;
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(1, 11);
    idle(2);
    chk("t2_count", 32'(seen_q.size()), 8);
    chk("t2_first", 32'(seen_q[0]), 4);
    chk("t2_last", 32'(seen_q[7]), 11);
    chk("t2_credits", 32'(credits), 0);
    cfg_offset = '0;
    // No credit: drop, then return and retry
    seen_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 0);
    idle(1);
    chk("t3_drop_cnt", 32'(drop_cnt), 1);
    chk("t3_overflow", 32'(overflow), 1);
    samples(1, 8);
    idle(2);
    chk("t3_no_output", 32'(seen_q.size()), 0);
    cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(21, 8);
    idle(2);
    chk("t3_retry_count", 32'(seen_q.size()), 8);
    chk("t3_retry_first", 32'(seen_q[0]), 21);
    // Same-cycle return and trigger
    cyc(1'b1, 1'b1, 1'b0, 0);
    idle(1);
    chk("t4_drop_cnt", 32'(drop_cnt), 2);
    chk("t4_credits_0", 32'(credits), 1);
    chk("t4_not_busy", 32'(busy), 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    idle(1);
    chk("t4_credits_1", 32'(credits), 1);
    chk("t4_busy", 32'(busy), 1);
    samples(40, 8);
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(50, 8);
    idle(2);
    chk("t4_empty", 32'(credits), 0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 0);
    idle(1);
    chk("drop_saturate", 32'(drop_cnt), DROP_MAX);
    // Disable mid-burst
    cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0);
    seen_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(1, 3);
    cfg_enable = 1'b0;
    samples(4, 5);
    idle(2);
    chk("t5_count", 32'(seen_q.size()), 8);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_credits", 32'(credits), 1);
    seen_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(1, 4);
    idle(1);
    chk("t5_disabled_trig", 32'(seen_q.size()), 0);
    // Reset mid-burst
    cfg_enable = 1'b1;
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 0);
    samples(1, 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_credits", 32'(credits), 2);
    chk("t5_rst_busy", 32'(busy), 0);
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0);
    idle(1);
    chk("credit_err", 32'(credit_err), 1);
`endif
    // Random phase against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in); #1;
      rst        = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
      cfg_offset = OW'($urandom_range(0, 4));
      trig       = ($urandom_range(0, 9) == 0);
      rd_done    = ($urandom_range(0, 11) == 0);
      s_valid    = ($urandom_range(0, 9) < 7);
      s_data_i   = DW'($urandom);
      s_data_q   = DW'($urandom);
    end
    rst = 1'b0;
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
